// File: rtl/tts_pkg.sv
// Shared types and sizing helpers for the truth-table scanner.
package tts_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  localparam int SETTLE_W = 4;

  function automatic int idx_width(input int n_in);
    return n_in;
  endfunction

  function automatic int tbl_size(input int n_in);
    return 1 << n_in;
  endfunction

endpackage

// File: rtl/tts_index_counter.sv
// Settle (hold) counter chained into the stimulus index counter; the index
// saturates at its terminal value instead of wrapping.
module tts_index_counter
  import tts_pkg::*;
#(
  parameter int IDX_W  = 3,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  output logic [IDX_W-1:0] index,
  output logic             settle_tc,
  output logic             index_tc
);

  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE - 1);
  localparam logic [IDX_W-1:0]    INDEX_LAST  = {IDX_W{1'b1}};

  logic [SETTLE_W-1:0] settle;

  assign settle_tc = (settle == SETTLE_LAST);
  assign index_tc  = (index == INDEX_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settle <= '0;
      index  <= '0;
    end else if (clear) begin
      settle <= '0;
      index  <= '0;
    end else if (enable) begin
      if (settle_tc) begin
        settle <= '0;
        if (!index_tc) index <= index + 1'b1;
      end else begin
        settle <= settle + 1'b1;
      end
    end
  end

endmodule

// File: rtl/truth_table_scanner.sv
// Walks every input combination of an external function, samples its output
// at the end of each hold and builds the maxterm mask and count.
module truth_table_scanner
  import tts_pkg::*;
#(
  parameter  int N_IN   = 3,
  parameter  int SETTLE = 1,
  localparam int IDX_W  = idx_width(N_IN),
  localparam int TBL    = tbl_size(N_IN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [IDX_W-1:0] stim,
  input  logic             f_in,
  output logic             busy,
  output logic             done,
  output logic             result_valid,
  output logic [TBL-1:0]   maxterm_mask,
  output logic [N_IN:0]    maxterm_count,
  output logic             is_const0,
  output logic             is_const1
);

  state_t           state, state_next;
  logic [IDX_W-1:0] index;
  logic             settle_tc, index_tc;
  logic             accept, sample, last_sample;
  logic [N_IN:0]    count_next;

  assign accept      = (state == IDLE) && start;
  assign sample      = (state == SCAN) && settle_tc;
  assign last_sample = sample && index_tc;
  assign count_next  = maxterm_count + {{N_IN{1'b0}}, ~f_in};

  // Clearing in DONE returns stim to 0 as the block drops back to IDLE.
  tts_index_counter #(
    .IDX_W (IDX_W),
    .SETTLE(SETTLE)
  ) u_counter (
    .clk      (clk),
    .rst      (rst),
    .clear    (accept || (state == DONE)),
    .enable   (state == SCAN),
    .index    (index),
    .settle_tc(settle_tc),
    .index_tc (index_tc)
  );

  assign stim = index;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SCAN;
      SCAN:    if (last_sample) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy          <= 1'b0;
      done          <= 1'b0;
      result_valid  <= 1'b0;
      maxterm_mask  <= '0;
      maxterm_count <= '0;
      is_const0     <= 1'b0;
      is_const1     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        busy          <= 1'b1;
        result_valid  <= 1'b0;
        maxterm_mask  <= '0;
        maxterm_count <= '0;
        is_const0     <= 1'b0;
        is_const1     <= 1'b0;
      end
      if (sample) begin
        maxterm_mask[index] <= ~f_in;
        maxterm_count       <= count_next;
      end
      if (last_sample) begin
        busy         <= 1'b0;
        done         <= 1'b1;
        result_valid <= 1'b1;
        is_const0    <= (count_next == (N_IN + 1)'(TBL));
        is_const1    <= (count_next == '0);
      end
    end
  end

endmodule

// File: tb/tb_truth_table_scanner.sv
// Bench for truth_table_scanner: three configurations checked every cycle
// against a cycle-count based model, plus literal expectations per scenario.
module tb_truth_table_scanner;

  localparam int NU = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_in   [NU] = '{3, 4, 3};
  int settle [NU] = '{1, 1, 3};

  bit        start     [NU];
  bit [63:0] tbl       [NU];
  bit        glitch_en [NU];
  bit        glitch    [NU];

  logic        d_busy [NU];
  logic        d_done [NU];
  logic        d_rv   [NU];
  logic        d_c0   [NU];
  logic        d_c1   [NU];
  logic [63:0] d_stim [NU];
  logic [63:0] d_mask [NU];
  logic [63:0] d_cnt  [NU];

  logic [2:0]  stim_a, stim_c;
  logic [3:0]  stim_b;
  logic [7:0]  mask_a, mask_c;
  logic [15:0] mask_b;
  logic [3:0]  cnt_a, cnt_c;
  logic [4:0]  cnt_b;
  wire f_a = tbl[0][stim_a] ^ glitch[0];
  wire f_b = tbl[1][stim_b] ^ glitch[1];
  wire f_c = tbl[2][stim_c] ^ glitch[2];

  assign d_stim[0] = 64'(stim_a);
  assign d_stim[1] = 64'(stim_b);
  assign d_stim[2] = 64'(stim_c);
  assign d_mask[0] = 64'(mask_a);
  assign d_mask[1] = 64'(mask_b);
  assign d_mask[2] = 64'(mask_c);
  assign d_cnt[0]  = 64'(cnt_a);
  assign d_cnt[1]  = 64'(cnt_b);
  assign d_cnt[2]  = 64'(cnt_c);

  truth_table_scanner #(.N_IN(3), .SETTLE(1)) u_a (
    .clk(clk), .rst(rst), .start(start[0]), .stim(stim_a), .f_in(f_a),
    .busy(d_busy[0]), .done(d_done[0]), .result_valid(d_rv[0]),
    .maxterm_mask(mask_a), .maxterm_count(cnt_a),
    .is_const0(d_c0[0]), .is_const1(d_c1[0]));

  truth_table_scanner #(.N_IN(4), .SETTLE(1)) u_b (
    .clk(clk), .rst(rst), .start(start[1]), .stim(stim_b), .f_in(f_b),
    .busy(d_busy[1]), .done(d_done[1]), .result_valid(d_rv[1]),
    .maxterm_mask(mask_b), .maxterm_count(cnt_b),
    .is_const0(d_c0[1]), .is_const1(d_c1[1]));

  truth_table_scanner #(.N_IN(3), .SETTLE(3)) u_c (
    .clk(clk), .rst(rst), .start(start[2]), .stim(stim_c), .f_in(f_c),
    .busy(d_busy[2]), .done(d_done[2]), .result_valid(d_rv[2]),
    .maxterm_mask(mask_c), .maxterm_count(cnt_c),
    .is_const0(d_c0[2]), .is_const1(d_c1[2]));

  int n_checks = 0;
  int n_pass   = 0;
  int n_cyc_fail_lines = 0;

  function automatic bit [63:0] low_bits(input bit [63:0] v, input int n);
    bit [63:0] r;
    r = '0;
    for (int i = 0; i < n && i < 64; i++) r[i] = v[i];
    return r;
  endfunction

  function automatic int popc(input bit [63:0] v);
    int c;
    c = 0;
    for (int i = 0; i < 64; i++) c += int'(v[i]);
    return c;
  endfunction

  // Model: m_t counts cycles since the accepting edge (cycle 1 follows it).
  bit        m_act  [NU];
  int        m_t    [NU];
  bit        m_rv   [NU];
  bit [63:0] m_mask [NU];

  always @(posedge clk or posedge rst) begin
    for (int u = 0; u < NU; u++) begin
      if (rst) begin
        m_act[u]  <= 1'b0;
        m_t[u]    <= 0;
        m_rv[u]   <= 1'b0;
        m_mask[u] <= '0;
      end else if (m_act[u]) begin
        if (m_t[u] == (1 << n_in[u]) * settle[u] + 1) begin
          m_act[u]  <= 1'b0;
          m_rv[u]   <= 1'b1;
          m_mask[u] <= low_bits(~tbl[u], 1 << n_in[u]);
        end else begin
          m_t[u] <= m_t[u] + 1;
        end
      end else if (start[u]) begin
        m_act[u] <= 1'b1;
        m_t[u]   <= 1;
        m_rv[u]  <= 1'b0;
      end
    end
  end

  // f_in may toggle freely except in the last cycle of each hold.
  always @(negedge clk) begin
    for (int u = 0; u < NU; u++) begin
      bit samp;
      samp = m_act[u] && m_t[u] >= 1 && m_t[u] <= (1 << n_in[u]) * settle[u]
             && (m_t[u] % settle[u]) == 0;
      glitch[u] <= (glitch_en[u] && !samp) ? 1'($urandom) : 1'b0;
    end
  end

  always @(negedge clk) begin
    for (int u = 0; u < NU; u++) begin
      int        tt, ll, e_stim, e_cnt;
      bit [63:0] e_mask;
      bit        e_busy, e_done, e_rv, e_c0, e_c1;
      tt = 1 << n_in[u];
      ll = tt * settle[u];
      if (m_act[u]) begin
        e_mask = low_bits(~tbl[u], (m_t[u] - 1) / settle[u]);
        e_busy = (m_t[u] <= ll);
        e_done = (m_t[u] == ll + 1);
        e_rv   = e_done;
        e_stim = e_busy ? (m_t[u] - 1) / settle[u] : tt - 1;
      end else begin
        e_mask = m_mask[u];
        e_busy = 1'b0;
        e_done = 1'b0;
        e_rv   = m_rv[u];
        e_stim = 0;
      end
      e_cnt = popc(e_mask);
      e_c0  = e_rv && (e_cnt == tt);
      e_c1  = e_rv && (e_cnt == 0);
      n_checks++;
      if (d_stim[u] === 64'(e_stim) && d_busy[u] === e_busy && d_done[u] === e_done &&
          d_rv[u] === e_rv && d_mask[u] === e_mask && d_cnt[u] === 64'(e_cnt) &&
          d_c0[u] === e_c0 && d_c1[u] === e_c1) begin
        n_pass++;
      end else if (n_cyc_fail_lines < 30) begin
        n_cyc_fail_lines++;
        $display("FAIL cycle u%0d @%0t: got stim=%0h busy=%b done=%b rv=%b mask=%0h cnt=%0d c0=%b c1=%b; expected stim=%0h busy=%b done=%b rv=%b mask=%0h cnt=%0d c0=%b c1=%b",
                 u, $time, d_stim[u], d_busy[u], d_done[u], d_rv[u], d_mask[u], d_cnt[u], d_c0[u], d_c1[u],
                 e_stim, e_busy, e_done, e_rv, e_mask, e_cnt, e_c0, e_c1);
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  // Runs one scan; returns the cycle index (1 = cycle after acceptance) at
  // which done was seen and the number of cycles busy was high. Ends in IDLE.
  task automatic run_scan(input int u, input bit [63:0] t, input bit gl, input bit restart,
                          output int k, output int busy_n);
    tbl[u]       = t;
    glitch_en[u] = gl;
    @(negedge clk);
    start[u] = 1'b1;
    @(negedge clk);
    start[u] = 1'b0;
    busy_n = 0;
    for (k = 1; k <= 2000; k++) begin
      if (d_busy[u]) busy_n++;
      if (d_done[u]) break;
      if (restart && k == 3) start[u] = 1'b1;
      @(negedge clk);
      start[u] = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic check_results(input string tag, input int u, input logic [63:0] mask,
                               input int cnt, input bit c0, input bit c1);
    check({tag, " mask"}, d_mask[u], mask);
    check({tag, " count"}, d_cnt[u], 64'(cnt));
    check({tag, " is_const0"}, 64'(d_c0[u]), 64'(c0));
    check({tag, " is_const1"}, 64'(d_c1[u]), 64'(c1));
    check({tag, " result_valid"}, 64'(d_rv[u]), 64'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k, b, u, dn;
    bit [63:0] t;

    repeat (3) @(negedge clk);
    check("reset stim", d_stim[0], 64'd0);
    check("reset busy", 64'(d_busy[0]), 64'd0);
    check("reset rv", 64'(d_rv[0]), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_scan(0, 64'h33, 1'b0, 1'b0, k, b);
    check("A latency", 64'(k), 64'd9);
    check("A busy cycles", 64'(b), 64'd8);
    check_results("A", 0, 64'hCC, 4, 1'b0, 1'b0);

    run_scan(1, 64'hD9AA, 1'b0, 1'b0, k, b);
    check("B latency", 64'(k), 64'd17);
    check("B busy cycles", 64'(b), 64'd16);
    check_results("B", 1, 64'h2655, 7, 1'b0, 1'b0);

    run_scan(2, 64'h52, 1'b1, 1'b0, k, b);
    check("C latency", 64'(k), 64'd25);
    check("C busy cycles", 64'(b), 64'd24);
    check_results("C", 2, 64'hAD, 5, 1'b0, 1'b0);

    run_scan(0, 64'h00, 1'b0, 1'b0, k, b);
    check_results("const0", 0, 64'hFF, 8, 1'b1, 1'b0);
    run_scan(0, 64'hFF, 1'b0, 1'b0, k, b);
    check_results("const1", 0, 64'h00, 0, 1'b0, 1'b1);

    run_scan(0, 64'h33, 1'b0, 1'b1, k, b);
    check("restart latency", 64'(k), 64'd9);
    check_results("restart", 0, 64'hCC, 4, 1'b0, 1'b0);

    // Asynchronous abort in the middle of a scan.
    tbl[0] = 64'h33;
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    for (int i = 0; i < 20 && d_stim[0] != 64'd5; i++) @(negedge clk);
    check("abort stim before reset", d_stim[0], 64'd5);
    #2 rst = 1'b1;
    #1;
    check("abort stim", d_stim[0], 64'd0);
    check("abort busy", 64'(d_busy[0]), 64'd0);
    check("abort rv", 64'(d_rv[0]), 64'd0);
    check("abort mask", d_mask[0], 64'd0);
    check("abort count", d_cnt[0], 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    dn = 0;
    repeat (12) begin
      @(negedge clk);
      if (d_done[0]) dn++;
    end
    check("abort no done", 64'(dn), 64'd0);
    run_scan(0, 64'h33, 1'b0, 1'b0, k, b);
    check("post-abort latency", 64'(k), 64'd9);
    check_results("post-abort", 0, 64'hCC, 4, 1'b0, 1'b0);

    for (int r = 0; r < 12; r++) begin
      u = $urandom_range(0, NU - 1);
      t = {$urandom, $urandom};
      run_scan(u, t, 1'($urandom), 1'($urandom), k, b);
      check("random latency", 64'(k), 64'((1 << n_in[u]) * settle[u] + 1));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/truth_table_scanner.md
Name: truth_table_scanner

Overview:
Sequential truth-table extractor, the inverse of the PoS expression evaluator. The evaluator turns a maxterm list into an output. This block drives every input combination into an external combinational function under test, samples its output and builds the maxterm list (Π M) plus summary counts. It sits beside the boolean-expression modules as a self-checking harness block, replacing hand-written #1 stimulus sequences.

Parameters:
N_IN, 3, number of function inputs (legal 2..6); stim index 0..2**N_IN-1
SETTLE, 1, cycles each stimulus is held before sampling (legal 1..15)

Ports:
clk  in  1  rising-edge clock
rst  in  1  reset, asynchronous, active-high
start  in  1  request a scan; accepted only in IDLE
stim  out  N_IN  input vector to the function under test; MSB = X, LSB = Z (index order X Y W Z)
f_in  in  1  function output for current stim
busy  out  1  high while scanning
done  out  1  one-cycle pulse when the scan completes
result_valid  out  1  high from done until the next accepted start
maxterm_mask  out  2**N_IN  bit i = 1 when F(i) = 0
maxterm_count  out  N_IN+1  number of maxterms found
is_const0  out  1  maxterm_count == 2**N_IN (and result_valid)
is_const1  out  1  maxterm_count == 0 (and result_valid)

Behaviour:
- Reset (async, any state): state=IDLE; stim=0, busy=0, done=0, result_valid=0, maxterm_mask=0, maxterm_count=0, is_const0=0, is_const1=0. Internal index and settle counters are 0.
- States: IDLE, SCAN, DONE.
- IDLE:
  - start=1 → SCAN next cycle.
  - On that same edge: index=0, settle=0, stim=0, mask=0, count=0, result_valid=0, busy=1.
- SCAN:
  - stim = index (registered).
  - Each cycle settle increments.
  - When settle == SETTLE-1:
    - mask[index] <= ~f_in.
    - count += ~f_in.
    - settle <= 0.
    - If index == 2**N_IN-1 → DONE, busy <= 0. Else index <= index+1, and stim takes the new value the same edge.
  - Each stimulus is therefore held exactly SETTLE cycles. Sampling occurs at the last cycle of the hold.
- DONE (one cycle):
  - done=1, result_valid=1, then → IDLE.
  - stim returns to 0 on the IDLE transition.
- Latency: the start-acceptance edge to the done-high cycle is 2**N_IN*SETTLE + 1 cycles. The final sample is taken on the edge entering DONE.
- start is ignored in SCAN and DONE; no queuing.
- Results (mask, count, flags) hold until the next accepted start, which clears them.
- is_const0 and is_const1 are registered and updated on the edge entering DONE.
- f_in is sampled only at the hold's last cycle. Glitches earlier in the hold are ignored.
- Index wrap: none. Index never exceeds 2**N_IN-1, and the counter stops at the terminal value.
- Reset mid-scan: immediate abort, no done pulse, results cleared, stim=0.
- Count is N_IN+1 bits, so the all-maxterms case does not overflow.

Decomposition:
- Package tts_pkg: state enum {IDLE, SCAN, DONE}; localparam function for index width (N_IN) and table size (2**N_IN); settle counter width (4 bits).
- One sub-module is natural: tts_index_counter. It holds the settle counter plus index counter, with clear, enable and terminal-count outputs. The FSM and the mask/count accumulation stay in the top.

Test Plan:
- N_IN=3, SETTLE=1, DUT F=Π M(2,3,6,7) → stim steps 0..7 one per cycle; done 9 cycles after start edge; maxterm_mask=8'b1100_1100, maxterm_count=4, is_const0=0, is_const1=0.
- N_IN=4, SETTLE=1, DUT F=Π M(0,2,4,6,9,10,13) → maxterm_mask=16'h2655, maxterm_count=7; busy high for exactly 16 cycles.
- N_IN=3, SETTLE=3, DUT F=Π M(0,2,3,5,7) → each stim value held 3 cycles; done 25 cycles after start; maxterm_mask=8'b1010_1101, count=5.
- Constant DUTs (N_IN=3): f_in=0 → mask=8'hFF, count=8, is_const0=1; f_in=1 → mask=0, count=0, is_const1=1.
- start pulsed again at cycle 3 of a scan → ignored, same done timing and result. A second start after done clears result_valid the next cycle, then re-scans identically.
- rst asserted mid-scan (stim=5) → all outputs 0 asynchronously, no done pulse. After release, a new start performs a full clean scan.
